sipo_capture_reg: RTL and testbench
===================================

// Module: sipo_capture_reg
// PURPOSE
//   Serial-in/parallel-out capture stage. Sits directly downstream of the single-bit
//   D flip-flop stage and consumes its registered q_out one bit per enabled clock.
//   Assembles WIDTH-bit words and presents each with a valid/ack handshake.
//   Flags overrun when a word completes before the previous one is taken.
// PARAMETERS
//   WIDTH      8   word width in bits; legal range 2..32
//   MSB_FIRST  1   1: first received bit lands in data_out[WIDTH-1]; 0: lands in data_out[0]
// PORTS
//   clk             in   1      single clock; all state changes on posedge clk
//   reset_in        in   1      synchronous, active-high reset
//   serial_in       in   1      serial bit from upstream flip-flop q_out
//   shift_en_in     in   1      1 = sample serial_in on this edge
//   clear_in        in   1      synchronous abort/clear; active-high
//   ack_in          in   1      consumer accepts data_out when valid_out=1
//   data_out        out  WIDTH  last completed word (registered)
//   valid_out       out  1      data_out holds an un-acked word
//   overrun_out     out  1      sticky: a completed word was dropped
//   parity_err_out  out  1      parity status of data_out (see CONFIGURATION)
// BEHAVIOUR
//   - Priority per edge: reset_in > clear_in > shift/handshake.
//   - Reset: data_out=0, valid_out=0, overrun_out=0, parity_err_out=0, shift reg=0, bit count=0.
//   - clear_in: same as reset. Any partial frame is discarded.
//   - Internal state: shift reg (WIDTH bits), bit counter 0..FRAME-1.
//     FRAME is WIDTH, or WIDTH+1 when PARITY_EN is defined.
//   - Shift on shift_en_in=1:
//     - MSB_FIRST=1: shift left, serial_in enters bit 0.
//     - MSB_FIRST=0: shift right, serial_in enters bit WIDTH-1.
//     - shift_en_in=0: shift reg and counter hold.
//   - Completion: the edge that samples the last frame bit (count==FRAME-1, shift_en_in=1):
//     - builds the word from the shift reg plus that incoming bit;
//     - resets the counter to 0; shifting of the next frame continues without a gap;
//     - updates data_out/valid_out on that same edge (zero extra latency).
//   - Handshake: valid_out=1 & ack_in=1 on an edge -> valid_out=0 after that edge,
//     unless a completion occurs on the same edge.
//   - Completion with valid_out=0, or with valid_out=1 & ack_in=1:
//     data_out <= new word, valid_out <= 1, no overrun.
//   - Completion with valid_out=1 & ack_in=0:
//     new word dropped, data_out/valid_out unchanged, overrun_out <= 1.
//   - overrun_out stays set until reset_in or clear_in.
//   - ack_in while valid_out=0 has no effect.
//   - data_out is stable whenever valid_out=1 and no accepted completion occurs.
// CONFIGURATION
//   - Macro SIPO_CAPTURE_PARITY_EN defined:
//     - FRAME = WIDTH+1; the last serial bit is an even-parity bit over the WIDTH data bits;
//     - the parity bit is not stored in data_out;
//     - parity_err_out loads with data_out on each accepted completion:
//       1 if XOR(data bits, parity bit) != 0;
//     - parity_err_out holds until the next accepted completion, clear_in or reset_in.
//   - Macro not defined: FRAME = WIDTH; parity_err_out is tied to 0.
// TESTING (WIDTH=8 unless noted; MSB_FIRST=1)
//   1 Reset: reset_in=1 for 2 cycles mid-frame -> all outputs 0; the next frame starts at bit 0.
//   2 Basic capture: shift 1,0,1,0,0,1,0,1 with shift_en_in=1 continuously
//     -> data_out=8'hA5 and valid_out=1 on the 8th edge.
//     Then ack_in=1 for 1 cycle -> valid_out=0.
//   3 Gapped enable: same bits with shift_en_in=0 for 3 cycles after bit 4
//     -> data_out=8'hA5; valid_out rises only on the edge sampling bit 8.
//   4 Overrun: two back-to-back frames 8'h3C then 8'hC3, ack_in=0 throughout
//     -> data_out=8'h3C, overrun_out=1.
//     Repeat with ack_in=1 on the second completion edge
//     -> data_out=8'hC3, valid_out=1, overrun_out=0.
//   5 Clear: clear_in=1 after 5 bits -> valid_out=0, overrun_out=0.
//     The next 8 bits 8'hFF -> data_out=8'hFF.
//     MSB_FIRST=0 with the same stream as scenario 2 -> data_out=8'hA5 bit-reversed = 8'hA5.
//   6 Parity (SIPO_CAPTURE_PARITY_EN): 8'hA5 + parity 0 -> parity_err_out=0;
//     8'hA5 + parity 1 -> parity_err_out=1, data_out=8'hA5.

Source files
------------

// File: rtl/sipo_capture_reg.sv
// Serial-in/parallel-out capture stage with valid/ack handoff and sticky overrun.
// Optional even-parity frame bit enabled by defining SIPO_CAPTURE_PARITY_EN.
module sipo_capture_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic             serial_in,
    input  logic             shift_en_in,
    input  logic             clear_in,
    input  logic             ack_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             overrun_out,
    output logic             parity_err_out
);

`ifdef SIPO_CAPTURE_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    // The shift register only ever needs the FRAME-1 bits preceding the final one;
    // the final bit is taken straight from serial_in on the completing edge.
    localparam int SW = FRAME - 1;
    localparam int CW = $clog2(FRAME);

    logic [SW-1:0]    shift_reg, shift_next, shifted;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] data_reg, data_next, word;
    logic             valid_reg, valid_next;
    logic             overrun_reg, overrun_next;
    logic             perr_reg, perr_next, word_perr;
    logic             complete;

    genvar gi;
    generate
        for (gi = 0; gi < SW; gi++) begin : g_shift
            if (MSB_FIRST) begin : g_msb
                if (gi == 0) begin : g_in
                    assign shifted[gi] = serial_in;
                end else begin : g_mv
                    assign shifted[gi] = shift_reg[gi-1];
                end
            end else begin : g_lsb
                if (gi == SW - 1) begin : g_in
                    assign shifted[gi] = serial_in;
                end else begin : g_mv
                    assign shifted[gi] = shift_reg[gi+1];
                end
            end
        end
    endgenerate

`ifdef SIPO_CAPTURE_PARITY_EN
    // Data bits are all in the shift register; serial_in carries the parity bit.
    assign word      = shift_reg;
    assign word_perr = (^shift_reg) ^ serial_in;
`else
    assign word      = MSB_FIRST ? {shift_reg, serial_in} : {serial_in, shift_reg};
    assign word_perr = 1'b0;
`endif

    assign complete = shift_en_in && (count_reg == CW'(FRAME - 1));

    always_comb begin
        shift_next   = shift_reg;
        count_next   = count_reg;
        data_next    = data_reg;
        valid_next   = valid_reg;
        overrun_next = overrun_reg;
        perr_next    = perr_reg;

        if (valid_reg && ack_in) begin
            valid_next = 1'b0;
        end
        if (shift_en_in) begin
            shift_next = shifted;
            count_next = complete ? '0 : count_reg + CW'(1);
        end
        if (complete) begin
            if (!valid_reg || ack_in) begin
                data_next  = word;
                valid_next = 1'b1;
                perr_next  = word_perr;
            end else begin
                overrun_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_in || clear_in) begin
            shift_reg   <= '0;
            count_reg   <= '0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
            perr_reg    <= 1'b0;
        end else begin
            shift_reg   <= shift_next;
            count_reg   <= count_next;
            data_reg    <= data_next;
            valid_reg   <= valid_next;
            overrun_reg <= overrun_next;
            perr_reg    <= perr_next;
        end
    end

    assign data_out       = data_reg;
    assign valid_out      = valid_reg;
    assign overrun_out    = overrun_reg;
    assign parity_err_out = perr_reg;

endmodule

// File: tb/tb_sipo_capture_reg.sv
// Bench for sipo_capture_reg: MSB-first and LSB-first instances share one stimulus
// stream and are checked every cycle against a frame-queue reference model.
module tb_sipo_capture_reg;
    localparam int W = 8;
`ifdef SIPO_CAPTURE_PARITY_EN
    localparam int FRAME = W + 1;
    localparam bit PE = 1'b1;
`else
    localparam int FRAME = W;
    localparam bit PE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_in = 1'b1;
    logic         serial_in = 1'b0;
    logic         shift_en_in = 1'b0;
    logic         clear_in = 1'b0;
    logic         ack_in = 1'b0;
    logic [W-1:0] data_m, data_l;
    logic         valid_m, valid_l, ovr_m, ovr_l, perr_m, perr_l;

    int n_cmp = 0;
    int n_fail = 0;

    // reference model state
    bit           q[$];
    logic [W-1:0] exp_data_m = '0, exp_data_l = '0;
    logic         exp_valid = 1'b0, exp_ovr = 1'b0, exp_perr = 1'b0;

    always #5 clk = ~clk;

    sipo_capture_reg #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset_in(reset_in), .serial_in(serial_in), .shift_en_in(shift_en_in),
        .clear_in(clear_in), .ack_in(ack_in), .data_out(data_m), .valid_out(valid_m),
        .overrun_out(ovr_m), .parity_err_out(perr_m));

    sipo_capture_reg #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset_in(reset_in), .serial_in(serial_in), .shift_en_in(shift_en_in),
        .clear_in(clear_in), .ack_in(ack_in), .data_out(data_l), .valid_out(valid_l),
        .overrun_out(ovr_l), .parity_err_out(perr_l));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit s, input bit en, input bit ack, input bit clr, input bit rst);
        bit pre_valid;
        bit par;
        if (rst || clr) begin
            q.delete();
            exp_data_m = '0; exp_data_l = '0;
            exp_valid = 1'b0; exp_ovr = 1'b0; exp_perr = 1'b0;
            return;
        end
        pre_valid = exp_valid;
        if (pre_valid && ack) exp_valid = 1'b0;
        if (en) begin
            q.push_back(s);
            if (q.size() == FRAME) begin
                if (!pre_valid || ack) begin
                    par = 1'b0;
                    for (int i = 0; i < FRAME; i++) par ^= q[i];
                    for (int i = 0; i < W; i++) begin
                        exp_data_m[W-1-i] = q[i];
                        exp_data_l[i]     = q[i];
                    end
                    exp_perr  = PE ? par : 1'b0;
                    exp_valid = 1'b1;
                end else begin
                    exp_ovr = 1'b1;
                end
                q.delete();
            end
        end
    endtask

    task automatic step(input bit s, input bit en, input bit ack, input bit clr, input bit rst);
        serial_in = s; shift_en_in = en; ack_in = ack; clear_in = clr; reset_in = rst;
        @(posedge clk);
        model_edge(s, en, ack, clr, rst);
        #1;
        chk("data_msb", 32'(data_m), 32'(exp_data_m));
        chk("data_lsb", 32'(data_l), 32'(exp_data_l));
        chk("valid", {valid_m, valid_l}, {exp_valid, exp_valid});
        chk("overrun", {ovr_m, ovr_l}, {exp_ovr, exp_ovr});
        chk("parity_err", {perr_m, perr_l}, {exp_perr, exp_perr});
        $display("t=%0t s=%0b en=%0b ack=%0b clr=%0b rst=%0b -> dm=%h dl=%h v=%0b ov=%0b pe=%0b",
                 $time, s, en, ack, clr, rst, data_m, data_l, valid_m, ovr_m, perr_m);
    endtask

    // Sends one frame, first data bit = w[7]; optional 3-cycle enable gap before bit index gap_at.
    task automatic send_word(input logic [W-1:0] w, input bit par, input int gap_at, input bit ack_last);
        bit b;
        for (int i = 0; i < FRAME; i++) begin
            b = (i < W) ? w[W-1-i] : par;
            if (i == gap_at) repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            step(b, 1'b1, ack_last && (i == FRAME - 1), 1'b0, 1'b0);
        end
    endtask

    initial begin
        // reset, then reset again mid-frame
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("reset_valid", 32'(valid_m), 0);
        step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 1); step(0, 1, 0, 0, 1);
        chk("midreset_data", 32'(data_m), 0);

        // basic capture then ack
        send_word(8'hA5, 1'b0, -1, 1'b0);
        chk("basic_data", 32'(data_m), 32'hA5);
        chk("basic_data_lsb", 32'(data_l), 32'hA5);
        chk("basic_valid", 32'(valid_m), 1);
        step(0, 0, 1, 0, 0);
        chk("ack_valid", 32'(valid_m), 0);

        // gapped enable
        send_word(8'hA5, 1'b0, 4, 1'b0);
        chk("gap_data", 32'(data_m), 32'hA5);
        step(0, 0, 1, 0, 0);

        // overrun, then back-to-back with ack on second completion
        send_word(8'h3C, 1'b0, -1, 1'b0);
        send_word(8'hC3, 1'b0, -1, 1'b0);
        chk("ovr_data", 32'(data_m), 32'h3C);
        chk("ovr_flag", 32'(ovr_m), 1);
        step(0, 0, 0, 1, 0);
        send_word(8'h3C, 1'b0, -1, 1'b0);
        send_word(8'hC3, 1'b0, -1, 1'b1);
        chk("b2b_data", 32'(data_m), 32'hC3);
        chk("b2b_valid", 32'(valid_m), 1);
        chk("b2b_ovr", 32'(ovr_m), 0);

        // clear mid-frame after an overrun
        send_word(8'h11, 1'b0, -1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(0, 0, 0, 1, 0);
        chk("clr_valid", 32'(valid_m), 0);
        chk("clr_ovr", 32'(ovr_m), 0);
        send_word(8'hFF, 1'b0, -1, 1'b0);
        chk("clr_next_data", 32'(data_m), 32'hFF);
        step(0, 0, 1, 0, 0);

`ifdef SIPO_CAPTURE_PARITY_EN
        send_word(8'hA5, 1'b0, -1, 1'b0);
        chk("par_ok", 32'(perr_m), 0);
        step(0, 0, 1, 0, 0);
        send_word(8'hA5, 1'b1, -1, 1'b0);
        chk("par_err", 32'(perr_m), 1);
        chk("par_data", 32'(data_m), 32'hA5);
        step(0, 0, 1, 0, 0);
`endif

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom), $urandom_range(3, 0) != 0, $urandom_range(9, 0) < 3,
                 $urandom_range(99, 0) < 2, $urandom_range(199, 0) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
